// File: rtl/mac_secuenciador_pkg.sv
// mac_secuenciador_pkg
// Shared definitions for the MAC sequencer slice: FSM state encoding,
// tap-index width helper and default sizing constants.
package mac_secuenciador_pkg;

  // Default sizing: 25-bit data/coefficients, 5 taps, Q10.15 coefficients
  localparam int N_DEF    = 25;
  localparam int TAPS_DEF = 5;
  localparam int F_DEF    = 15;

  // Largest unsigned N_DEF-bit value, used as the output saturation level
  localparam logic [N_DEF-1:0] SAT_MAX = {N_DEF{1'b1}};

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } estado_e;

  // Width of a tap index; at least one bit even for a single tap
  function automatic int idx_ancho(input int taps);
    if (taps > 1) begin
      return $clog2(taps);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mac_secuenciador_coef_banco.sv
// coef_banco
// TAPS x N coefficient register bank with a gated write port and a
// combinational read port.
// Ports:
//   clk, reset_n    clock, async active-low clear of every coefficient
//   idle            write qualifier: writes only land while the sequencer idles
//   we, addr, data  write port; addresses >= TAPS are ignored
//   rd_addr         read index (tap currently in the MAC)
//   rd_data         coefficient at rd_addr (0 for out-of-range index)
module coef_banco
  import mac_secuenciador_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int AW   = idx_ancho(TAPS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          idle,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0] h_r [TAPS];
  logic         wr_ok_s;

  // Write qualification: idle only, in-range address only
  always_comb begin
    wr_ok_s = 1'b0;
    if (we && idle && (int'(addr) < TAPS)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Coefficient storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++) begin
        h_r[k] <= {N{1'b0}};
      end
    end else if (wr_ok_s) begin
      h_r[addr] <= data;
    end
  end

  // Combinational read, guarded against indices past the last tap
  always_comb begin
    rd_data = {N{1'b0}};
    if (int'(rd_addr) < TAPS) begin
      rd_data = h_r[rd_addr];
    end else begin
      rd_data = {N{1'b0}};
    end
  end

endmodule

// File: rtl/mac_secuenciador.sv
// mac_secuenciador
// Sequencer in front of the combinational MAC stage. Each accepted sample
// shifts a TAPS-deep delay line, then one tap per cycle is presented to the
// MAC together with the running accumulator, whose result is captured back.
// After the last tap the accumulator is shifted down by F, saturated to N
// bits and published on y_out with a one-cycle y_valid pulse.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   sample_in, sample_valid       new sample (accepted only while idle)
//   coef_we, coef_addr, coef_data coefficient write port (idle only)
//   mac_mult, mac_const           tap sample / coefficient to the MAC
//   mac_sum_ext                   running accumulator to the MAC addend
//   mac_suma_g                    MAC result (mult*const + sum_ext)
//   y_out, y_valid                filter output and its update pulse
//   busy                          a sample is being processed
//   sample_drop                   pulse: a sample arrived while busy
module mac_secuenciador
  import mac_secuenciador_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int F    = F_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N-1:0]               sample_in,
  input  logic                       sample_valid,
  input  logic                       coef_we,
  input  logic [idx_ancho(TAPS)-1:0] coef_addr,
  input  logic [N-1:0]               coef_data,
  output logic [N-1:0]               mac_mult,
  output logic [N-1:0]               mac_const,
  output logic [2*N-1:0]             mac_sum_ext,
  input  logic [2*N-1:0]             mac_suma_g,
  output logic [N-1:0]               y_out,
  output logic                       y_valid,
  output logic                       busy,
  output logic                       sample_drop
);

  localparam int            IW       = idx_ancho(TAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);
  localparam logic [N-1:0]  SAT_C    = {N{1'b1}};

  // acc >> F, clipped to the all-ones N-bit value if anything remains above bit N-1
  function automatic logic [N-1:0] saturar(input logic [2*N-1:0] acc);
    logic [2*N-1:0] sh;
    sh = acc >> F;
    if (|sh[2*N-1:N]) begin
      return SAT_C;
    end else begin
      return sh[N-1:0];
    end
  endfunction

  estado_e         state_r;
  estado_e         state_n;
  logic [N-1:0]    x_r [TAPS];
  logic [2*N-1:0]  acc_r;
  logic [IW-1:0]   idx_r;
  logic [N-1:0]    y_out_r;
  logic            y_valid_r;
  logic            busy_r;
  logic            drop_r;

  logic            idle_s;
  logic            accept_s;
  logic            last_s;
  logic [N-1:0]    h_s;
  logic [N-1:0]    mac_mult_s;
  logic [N-1:0]    mac_const_s;

  coef_banco #(
    .N    (N),
    .TAPS (TAPS),
    .AW   (IW)
  ) u_coef_banco (
    .clk     (clk),
    .reset_n (reset_n),
    .idle    (idle_s),
    .we      (coef_we),
    .addr    (coef_addr),
    .data    (coef_data),
    .rd_addr (idx_r),
    .rd_data (h_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic and MAC operand steering
  always_comb begin
    state_n     = state_r;
    mac_mult_s  = {N{1'b0}};
    mac_const_s = {N{1'b0}};
    idle_s      = 1'b0;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        idle_s = 1'b1;
        if (sample_valid) begin
          accept_s = 1'b1;
          state_n  = ST_MAC;
        end else begin
          state_n  = ST_IDLE;
        end
      end
      ST_MAC: begin
        mac_mult_s  = x_r[idx_r];
        mac_const_s = h_s;
        if (idx_r == LAST_IDX) begin
          last_s  = 1'b1;
          state_n = ST_DONE;
        end else begin
          state_n = ST_MAC;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Delay line: shifts only when a sample is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_r[k] <= {N{1'b0}};
      end
    end else if (accept_s) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        x_r[k] <= x_r[k-1];
      end
      x_r[0] <= sample_in;
    end
  end

  // Accumulator and tap index: cleared on accept, stepped each MAC cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r <= {(2*N){1'b0}};
      idx_r <= {IW{1'b0}};
    end else if (accept_s) begin
      acc_r <= {(2*N){1'b0}};
      idx_r <= {IW{1'b0}};
    end else if (state_r == ST_MAC) begin
      acc_r <= mac_suma_g;
      idx_r <= idx_r + IW'(1);
    end
  end

  // Registered status/outputs; y_out is loaded from the final MAC result
  // so that it is valid during the DONE cycle alongside y_valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_out_r   <= {N{1'b0}};
      y_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      drop_r    <= 1'b0;
    end else begin
      if (last_s) begin
        y_out_r <= saturar(mac_suma_g);
      end
      y_valid_r <= last_s;
      busy_r    <= (state_n != ST_IDLE);
      drop_r    <= sample_valid && !idle_s;
    end
  end

  assign mac_mult    = mac_mult_s;
  assign mac_const   = mac_const_s;
  assign mac_sum_ext = acc_r;
  assign y_out       = y_out_r;
  assign y_valid     = y_valid_r;
  assign busy        = busy_r;
  assign sample_drop = drop_r;

endmodule

// File: tb/tb_mac_secuenciador.sv
// tb_mac_secuenciador
// Directed bench for mac_secuenciador with a behavioural MAC stage
// (mult*const + sum_ext, wrapping at 2N bits) closing the loop.
module tb_mac_secuenciador;

  localparam int N    = 25;
  localparam int TAPS = 5;
  localparam int F    = 15;
  localparam int AW   = 3;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    sample_in;
  logic            sample_valid;
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [N-1:0]    coef_data;
  logic [N-1:0]    mac_mult;
  logic [N-1:0]    mac_const;
  logic [2*N-1:0]  mac_sum_ext;
  logic [2*N-1:0]  mac_suma_g;
  logic [N-1:0]    y_out;
  logic            y_valid;
  logic            busy;
  logic            sample_drop;

  int compared;
  int mismatched;

  logic [2*N-1:0] sum_log [0:21];

  mac_secuenciador #(.N(N), .TAPS(TAPS), .F(F)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .mac_mult     (mac_mult),
    .mac_const    (mac_const),
    .mac_sum_ext  (mac_sum_ext),
    .mac_suma_g   (mac_suma_g),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .busy         (busy),
    .sample_drop  (sample_drop)
  );

  // Behavioural MAC stage
  assign mac_suma_g = ({{N{1'b0}}, mac_mult} * {{N{1'b0}}, mac_const}) + mac_sum_ext;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset_n      = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    coef_we      = 1'b0;
    coef_addr    = '0;
    coef_data    = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [N-1:0] d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Sends one sample, waits (bounded) for y_valid. lat counts cycles from
  // acceptance to the y_valid cycle (-1 on timeout), bcnt counts busy cycles.
  task automatic send_sample(input logic [N-1:0] v, output logic [N-1:0] y,
                             output int lat, output int bcnt, output logic busy_after);
    @(negedge clk);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (lat <= 20 && !y_valid) begin
      if (busy) bcnt++;
      sum_log[lat] = mac_sum_ext;
      @(negedge clk);
      lat++;
    end
    if (lat > 20) begin
      lat = -1;
    end else if (busy) begin
      bcnt++;
    end
    y = y_out;
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sample_in = '0; sample_valid = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (2) @(negedge clk);
    compared++;
    if (y_out !== 25'd0 || y_valid !== 1'b0 || busy !== 1'b0 || sample_drop !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outs: y_out=%0d y_valid=%b busy=%b drop=%b, need 0/0/0/0",
               y_out, y_valid, busy, sample_drop);
    end
    compared++;
    if (mac_mult !== 25'd0 || mac_const !== 25'd0 || mac_sum_ext !== 50'd0) begin
      mismatched++;
      $display("FAIL reset_mac: mult=%0d const=%0d sum=%0d, need 0/0/0",
               mac_mult, mac_const, mac_sum_ext);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (y_out !== 25'd0 || y_valid !== 1'b0 || busy !== 1'b0 || sample_drop !== 1'b0 ||
        mac_sum_ext !== 50'd0) begin
      mismatched++;
      $display("FAIL reset_release: y_out=%0d y_valid=%b busy=%b drop=%b sum=%0d, need all 0",
               y_out, y_valid, busy, sample_drop, mac_sum_ext);
    end
  endtask

  task automatic test_identity();
    logic [N-1:0] y; int lat; int bcnt; logic ba;
    apply_reset();
    write_coef(3'd0, 25'd32768);
    send_sample(25'd100, y, lat, bcnt, ba);
    compared++;
    if (y !== 25'd100) begin mismatched++; $display("FAIL identity_y0: got %0d need 100", y); end
    compared++;
    if (lat !== 6) begin mismatched++; $display("FAIL identity_lat: got %0d need 6", lat); end
    compared++;
    if (bcnt !== 6 || ba !== 1'b0) begin
      mismatched++;
      $display("FAIL identity_busy: cycles %0d after %b, need 6 and 0", bcnt, ba);
    end
    send_sample(25'd200, y, lat, bcnt, ba);
    compared++;
    if (y !== 25'd200 || lat !== 6) begin
      mismatched++;
      $display("FAIL identity_y1: got %0d lat %0d, need 200 lat 6", y, lat);
    end
    // y_out holds between pulses
    repeat (3) @(negedge clk);
    compared++;
    if (y_out !== 25'd200 || y_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL identity_hold: y_out=%0d y_valid=%b, need 200/0", y_out, y_valid);
    end
  endtask

  task automatic test_delay();
    logic [N-1:0] y; int lat; int bcnt; logic ba;
    logic [N-1:0] exp_y [4];
    exp_y[0] = 25'd0; exp_y[1] = 25'd0; exp_y[2] = 25'd1; exp_y[3] = 25'd2;
    apply_reset();
    write_coef(3'd2, 25'd32768);
    for (int i = 0; i < 4; i++) begin
      send_sample(N'(i + 1), y, lat, bcnt, ba);
      compared++;
      if (y !== exp_y[i] || lat !== 6) begin
        mismatched++;
        $display("FAIL delay_%0d: got %0d lat %0d, need %0d lat 6", i, y, lat, exp_y[i]);
      end
    end
  endtask

  task automatic test_averaging();
    logic [N-1:0] y; int lat; int bcnt; logic ba;
    apply_reset();
    for (int a = 0; a < TAPS; a++) write_coef(AW'(a), 25'd16384);
    for (int i = 0; i < 5; i++) begin
      send_sample(25'd10, y, lat, bcnt, ba);
      compared++;
      if (y !== N'(5 * (i + 1))) begin
        mismatched++;
        $display("FAIL avg_%0d: got %0d need %0d", i, y, 5 * (i + 1));
      end
    end
    // Last sample had a full delay line: sum_ext steps by 10*16384 per tap
    for (int j = 1; j <= TAPS; j++) begin
      compared++;
      if (sum_log[j] !== 50'(163840 * (j - 1))) begin
        mismatched++;
        $display("FAIL avg_sum_ext_%0d: got %0d need %0d", j - 1, sum_log[j], 163840 * (j - 1));
      end
    end
  endtask

  task automatic test_saturation();
    logic [N-1:0] y; int lat; int bcnt; logic ba;
    apply_reset();
    write_coef(3'd0, 25'd33554431);
    send_sample(25'd33554431, y, lat, bcnt, ba);
    compared++;
    if (y !== 25'd33554431) begin
      mismatched++;
      $display("FAIL saturation: got %0d need 33554431", y);
    end
    // Just below saturation: 33554431 * 1.0 passes unchanged
    write_coef(3'd0, 25'd32768);
    send_sample(25'd33554431, y, lat, bcnt, ba);
    compared++;
    if (y !== 25'd33554431) begin
      mismatched++;
      $display("FAIL sat_edge: got %0d need 33554431", y);
    end
    // 2*(2^25-1) overflows the N-bit range and must clip
    write_coef(3'd0, 25'd65536);
    send_sample(25'd33554431, y, lat, bcnt, ba);
    compared++;
    if (y !== 25'd33554431) begin
      mismatched++;
      $display("FAIL sat_x2: got %0d need 33554431", y);
    end
  endtask

  task automatic test_busy_drop();
    logic [N-1:0] y; int lat; int bcnt; logic ba;
    apply_reset();
    write_coef(3'd0, 25'd32768);
    write_coef(3'd1, 25'd32768);
    send_sample(25'd7, y, lat, bcnt, ba);
    compared++;
    if (y !== 25'd7) begin mismatched++; $display("FAIL drop_first: got %0d need 7", y); end
    @(negedge clk);
    sample_in = 25'd11; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    // mid-MAC: a competing sample and a coefficient write
    sample_in = 25'd999; sample_valid = 1'b1;
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 25'd0;
    @(negedge clk);
    sample_valid = 1'b0; coef_we = 1'b0;
    compared++;
    if (sample_drop !== 1'b1) begin
      mismatched++;
      $display("FAIL drop_pulse: got %b need 1", sample_drop);
    end
    @(negedge clk);
    compared++;
    if (sample_drop !== 1'b0) begin
      mismatched++;
      $display("FAIL drop_single: got %b need 0", sample_drop);
    end
    lat = 0;
    while (!y_valid && lat < 20) begin @(negedge clk); lat++; end
    compared++;
    if (y_valid !== 1'b1 || y_out !== 25'd18) begin
      mismatched++;
      $display("FAIL drop_second: y_valid=%b y_out=%0d, need 1/18", y_valid, y_out);
    end
    @(negedge clk);
    send_sample(25'd13, y, lat, bcnt, ba);
    compared++;
    if (y !== 25'd24) begin
      mismatched++;
      $display("FAIL drop_third: got %0d need 24", y);
    end
  endtask

  task automatic test_coef_write_edges();
    logic [N-1:0] y; int lat; int bcnt; logic ba;
    apply_reset();
    // Write together with the accepted sample is used by that sample
    @(negedge clk);
    sample_in = 25'd50; sample_valid = 1'b1;
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 25'd32768;
    @(negedge clk);
    sample_valid = 1'b0; coef_we = 1'b0;
    lat = 1;
    while (!y_valid && lat < 20) begin @(negedge clk); lat++; end
    compared++;
    if (y_valid !== 1'b1 || y_out !== 25'd50 || lat !== 6) begin
      mismatched++;
      $display("FAIL same_cycle_write: y_valid=%b y_out=%0d lat=%0d, need 1/50/6",
               y_valid, y_out, lat);
    end
    // Out-of-range address changes nothing: h0 stays 1.0, others 0
    write_coef(3'd5, 25'd32768);
    write_coef(3'd7, 25'd32768);
    send_sample(25'd40, y, lat, bcnt, ba);
    compared++;
    if (y !== 25'd40) begin
      mismatched++;
      $display("FAIL addr_range: got %0d need 40", y);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    apply_reset();
    write_coef(3'd0, 25'd32768);
    @(negedge clk);
    sample_in = 25'd77; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0 || mac_sum_ext !== 50'd0) begin
      mismatched++;
      $display("FAIL reset_mid_busy: busy=%b sum=%0d, need 0/0", busy, mac_sum_ext);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (y_valid) seen++;
    end
    compared++;
    if (seen !== 0 || y_out !== 25'd0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_abandon: pulses=%0d y_out=%0d busy=%b, need 0/0/0",
               seen, y_out, busy);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_identity();
    test_delay();
    test_averaging();
    test_saturation();
    test_busy_drop();
    test_coef_write_edges();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
